// File: rtl/i2s_cap_pkg.sv
// Shared types and constants for the I2S ADC capture path.
// Holds no logic, so it adds no latency and has no backpressure.
package i2s_cap_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int SAMPLE_BITS_DEFAULT = 24;
    localparam int WORD_PAD            = 8;
    localparam int BYTE_ADDR_SHIFT     = 2;
endpackage

// File: rtl/i2s_edge_sync.sv
// Synchronises one I2S pin and flags any change of the synchronised level (toggle) one clk later.
// Latency is SYNC_STAGES+1 clk from pin to toggle; there is no backpressure.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic toggle
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // These flops are left out of reset on purpose. They keep tracking the pins during reset,
    // so a held-high lrclk does not look like a fresh edge when reset is released.
    always_ff @(posedge clk) begin
        sync_q <= SYNC_STAGES'({sync_q, din});
        prev   <= sync_q[SYNC_STAGES-1];
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign toggle = level ^ prev;
endmodule

// File: rtl/i2s_adc_capture.sv
// Deserialises left-justified I2S ADC data into a capture BRAM and mirrors each word on a 1-clk strobe (write = lrclk event + 1 clk).
// No backpressure: the BRAM always accepts; with I2S_CAP_MONO_EN defined only left words are written.
module i2s_adc_capture
    import i2s_cap_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
    parameter int DEPTH_WORDS = 30000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        i2s_bclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_adcdat,
    output logic [31:0] bram_addrb,
    output logic [31:0] bram_dinb,
    output logic [3:0]  bram_web,
    output logic        bram_enb,
    output logic        sample_valid,
    output logic        sample_left,
    output logic [31:0] sample_data,
    output logic        wrap
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    state_t                 state;
    logic                   chan;
    logic [SAMPLE_BITS-1:0] shift;
    logic [CW-1:0]          count;
    logic [AW-1:0]          addr;

    logic bclk_lvl, bclk_tgl, lr_lvl, lr_edge, dat_lvl, unused_dat_toggle;
    logic bclk_rise, full, commit;
    logic [31:0] word;

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .din(i2s_bclk), .level(bclk_lvl), .toggle(bclk_tgl));
    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(clk), .din(i2s_lrclk), .level(lr_lvl), .toggle(lr_edge));
    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adcdat (
        .clk(clk), .din(i2s_adcdat), .level(dat_lvl), .toggle(unused_dat_toggle));

    assign bclk_rise = bclk_lvl & bclk_tgl;
    assign full      = (count == CW'(SAMPLE_BITS));
    assign word      = 32'({shift, {WORD_PAD{1'b0}}});

`ifdef I2S_CAP_MONO_EN
    assign commit = (state == SHIFT) && lr_edge && full && chan;
`else
    assign commit = (state == SHIFT) && lr_edge && full;
`endif

    assign bram_addrb = 32'(addr) << BYTE_ADDR_SHIFT;
    assign bram_dinb  = sample_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            chan         <= 1'b0;
            shift        <= '0;
            count        <= '0;
            addr         <= '0;
            bram_web     <= '0;
            bram_enb     <= 1'b0;
            sample_valid <= 1'b0;
            sample_left  <= 1'b0;
            sample_data  <= '0;
            wrap         <= 1'b0;
        end else begin
            bram_web     <= '0;
            bram_enb     <= 1'b0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;

            // The address moves on in the cycle after the write it served.
            if (sample_valid) begin
                if (addr == AW'(DEPTH_WORDS - 1)) begin
                    addr <= '0;
                    wrap <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end

            if (commit) begin
                bram_web     <= 4'hF;
                bram_enb     <= 1'b1;
                sample_valid <= 1'b1;
                sample_left  <= chan;
                sample_data  <= word;
            end

            // An lrclk edge takes priority over a bclk rise in the same cycle.
            // In that case the rising bclk carries the MSB of the new channel.
            if (lr_edge) begin
                state <= enable ? SHIFT : IDLE;
                if (enable) begin
                    chan  <= lr_lvl;
                    shift <= bclk_rise ? SAMPLE_BITS'(dat_lvl) : '0;
                    count <= bclk_rise ? CW'(1) : '0;
                end
            end else if (state == SHIFT && bclk_rise && !full) begin
                shift <= {shift[SAMPLE_BITS-2:0], dat_lvl};
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_adc_capture.sv
// Randomised bench for i2s_adc_capture: a channel-level model predicts the committed words,
// and a monitor checks every BRAM write against the prediction queue.
module tb_i2s_adc_capture;
    // A short buffer keeps several address wraps inside a small cycle budget.
    localparam int DEPTH = 12;
    localparam int HALF  = 4;
    localparam int NCH   = 60;
`ifdef I2S_CAP_MONO_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_adcdat = 1'b0;
    logic [31:0] bram_addrb, bram_dinb, sample_data;
    logic [3:0]  bram_web;
    logic        bram_enb, sample_valid, sample_left, wrap;

    always #5 clk = ~clk;

    i2s_adc_capture #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_adcdat(i2s_adcdat),
        .bram_addrb(bram_addrb), .bram_dinb(bram_dinb), .bram_web(bram_web),
        .bram_enb(bram_enb), .sample_valid(sample_valid), .sample_left(sample_left),
        .sample_data(sample_data), .wrap(wrap));

    typedef struct {
        logic [31:0] data;
        logic        left;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_wraps = 0;
    int          n_wraps = 0;
    int          model_addr = 0;
    int          rst_cnt = 0;
    logic        mon_on = 1'b0;
    logic [31:0] last_addr = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write", bram_addrb, sample_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bram_addrb, e.addr);
                    chk("wr_data", sample_data, e.data);
                    chk("wr_dinb", bram_dinb, e.data);
                    chk("wr_left", 32'(sample_left), 32'(e.left));
                    chk("wr_web", 32'(bram_web), 32'hF);
                    chk("wr_enb", 32'(bram_enb), 32'd1);
                end
                last_addr = bram_addrb;
            end else begin
                chk("idle_web_enb", 32'({bram_web, bram_enb}), 32'd0);
            end
            if (wrap) begin
                n_wraps++;
                chk("wrap_from_addr", last_addr, 32'((DEPTH - 1) * 4));
            end
        end
    end

    initial begin
        logic [23:0] w;
        int          nbits;
        logic        left, cap, rst_hit;

        rst    = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_addr", bram_addrb, 32'd0);
        chk("rst_data", sample_data, 32'd0);
        chk("rst_dinb", bram_dinb, 32'd0);
        chk("rst_web", 32'(bram_web), 32'd0);
        chk("rst_enb", 32'(bram_enb), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_left", 32'(sample_left), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        mon_on = 1'b1;
        tick(3);

        // Each pass is one lrclk half-period. A channel is written at the next lrclk edge
        // only if capture was enabled at its own start edge, no reset hit it, and it held at least 24 bits.
        for (int c = 0; c < NCH; c++) begin
            left      = (c % 2 == 0);
            i2s_lrclk = left;
            w         = (c == 0) ? 24'hA55A3C : (c == 1) ? 24'h123456 : 24'($urandom);
            nbits     = (c < 2) ? 24 : (c == 11) ? 20 : (($urandom_range(0, 1) == 1) ? 26 : 24);
            cap       = enable;
            rst_hit   = 1'b0;
            for (int b = 0; b < nbits; b++) begin
                i2s_bclk   = 1'b0;
                i2s_adcdat = (b < 24) ? w[23-b] : 1'($urandom);
                if (c == 6 && b == 5)  enable = 1'b0;
                if (c == 9 && b == 5)  enable = 1'b1;
                if (c == 13 && b == 10) begin
                    rst        = 1'b1;
                    rst_cnt    = 5;
                    model_addr = 0;
                    rst_hit    = 1'b1;
                end
                if (c == 15 && b == 3)  enable = 1'b0;
                if (c == 16 && b == 12) enable = 1'b1;
                tick(HALF);
                i2s_bclk = 1'b1;
                tick(HALF);
            end
            if (c == 13) chk("addr_after_rst", bram_addrb, 32'd0);
            if (cap && !rst_hit && nbits >= 24 && (!MONO || left)) begin
                exp_q.push_back('{data: {w, 8'h00}, left: left, addr: 32'(model_addr * 4)});
                if (model_addr == DEPTH - 1) begin
                    exp_wraps++;
                    model_addr = 0;
                end else begin
                    model_addr++;
                end
            end
        end
        i2s_bclk  = 1'b0;
        i2s_lrclk = ~i2s_lrclk;
        tick(40);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_count", 32'(n_wraps), 32'(exp_wraps));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_adc_capture.md
Name: i2s_adc_capture

Overview:
- Receive side of the codec audio path: deserialises i2s_adcdat from the WM8731 (left-justified, MSB first, 24-bit stereo) into 32-bit words and writes them into a capture block RAM.
- Runs on clk (73.728 MHz). i2s_bclk and i2s_lrclk are inputs, taken from the existing clock dividers (bclk = clk/32, lrclk = clk/1536).
- Also presents each completed sample on a one-cycle valid strobe for loopback or monitoring logic.

Parameters:
- SAMPLE_BITS, 24, data bits captured per channel, MSB first.
- DEPTH_WORDS, 30000, capture buffer size in 32-bit words; the address wraps after the last word.
- SYNC_STAGES, 2, synchroniser flops on all three I2S inputs.

Ports:
- clk  in  1  system clock, 73.728 MHz.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  capture enable; sampled only at lrclk edges.
- i2s_bclk  in  1  bit clock.
- i2s_lrclk  in  1  word clock; 1 = left channel.
- i2s_adcdat  in  1  serial ADC data.
- bram_addrb  out  32  byte address, always a multiple of 4.
- bram_dinb  out  32  data word {sample[23:0], 8'h00}.
- bram_web  out  4  byte write enables; 4'hF when writing, else 0.
- bram_enb  out  1  port enable; high together with bram_web.
- sample_valid  out  1  one-cycle strobe when a word is committed.
- sample_left  out  1  channel of the committed word (1 = left).
- sample_data  out  32  committed word, same value as bram_dinb.
- wrap  out  1  one-cycle pulse when the address wraps to 0.

Behaviour:
- Reset: all outputs 0, address 0, state IDLE, shift register 0, bit count 0. Reset mid-frame discards the partial sample; capture restarts at the next lrclk edge.
- Input path: each input passes through SYNC_STAGES flops, plus one delay register for edge detection.
  - bclk_rise = sync bclk 0→1.
  - lr_edge = any sync lrclk transition.
  - Events are therefore seen 3 clk after the pin changes. All three inputs share identical delay, so alignment is preserved.
- States:
  - IDLE: on lr_edge with enable = 1, go to SHIFT. Latch chan = new lrclk level, clear shift register and bit count.
  - SHIFT: on each bclk_rise with count < SAMPLE_BITS, shift = {shift[22:0], adcdat} and count++. bclk_rise with count = SAMPLE_BITS is ignored (extra bits dropped).
  - On lr_edge from SHIFT, in the same cycle:
    - Commit the word if count == SAMPLE_BITS; a short channel is discarded with no write.
    - If enable = 1, restart SHIFT for the new channel; else go to IDLE.
- Commit cycle, registered one clk after lr_edge:
  - bram_web = F, bram_enb = 1, bram_dinb/sample_data = {shift, 8'h00}, sample_left = chan, sample_valid = 1.
  - bram_addrb holds the current word address × 4.
  - The address increments the following cycle. At word DEPTH_WORDS−1 it becomes 0 and wrap pulses in that cycle.
- Latency: last data bit's bclk_rise → write strobe is bounded by the next lr_edge + 1 clk.
- bclk_rise and lr_edge in the same cycle: the lr_edge is processed first and the bit is taken as the MSB of the new channel (left-justified MSB is valid at the first rising bclk after the lrclk edge).
- A first-channel word is never written from a partial frame after enable or reset.

Optional Feature:
- I2S_CAP_MONO_EN defined: only left-channel words are committed. Right channels are shifted but never written, so the address advances once per frame and sample_left is always 1.
- Undefined: L and R words are interleaved in the buffer, left first after any IDLE exit on a rising lrclk.

Decomposition:
- Package i2s_cap_pkg:
  - state enum {IDLE, SHIFT}
  - SAMPLE_BITS_DEFAULT = 24
  - WORD_PAD = 8
  - BYTE_ADDR_SHIFT = 2
- Sub-module i2s_edge_sync: SYNC_STAGES synchroniser plus edge detect for one input, instantiated three times.

Test Plan:
- Drive bclk = clk/32 and lrclk = clk/1536 with adcdat serialising L = 24'hA5_5A_3C and R = 24'h12_34_56 → writes 32'hA55A3C00 at addr 0 (sample_left = 1), then 32'h12345600 at addr 4.
- Run 30000 words with DEPTH_WORDS = 30000 → last write at addr 0x1D4BC, wrap pulses once, next write at addr 0.
- Deassert enable mid-left channel → that word is still written, then no writes until enable = 1 and a new lrclk edge; words resume left first.
- Assert rst for 5 clk at bit 10 of a channel → no write for that channel, address 0, next full channel is written at addr 0.
- Start enable with lrclk high mid-channel → the partial channel is dropped (only 12 bits captured); first write is the next full channel.
- With I2S_CAP_MONO_EN defined, 4 frames → 4 writes at addrs 0, 4, 8, C, all with sample_left = 1 and carrying left data only.
